// File: rtl/seqdet_pkg.sv
// Shared types and elaboration-time helpers for the parameterised sequence detector.
// Patterns are passed zero-extended to 16 bits, and bit width-1 is the first bit received.
package seqdet_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } seqdet_mode_e;

    localparam int SEQDET_MAX_W = 16;

    // Bit j of the string (matched k-bit prefix, then x), in arrival order.
    function automatic logic seqdet_sbit(input logic [SEQDET_MAX_W-1:0] pattern,
                                         input int width, input int k,
                                         input logic x, input int j);
        if (j < k)
            return pattern[4'(width - 1 - j)];
        return x;
    endfunction

    // Longest prefix (shorter than width) that is a suffix of (prefix_k, x).
    // A full match therefore falls back to the longest proper border.
    function automatic int seqdet_next(input logic [SEQDET_MAX_W-1:0] pattern,
                                       input int width, input int k, input logic x);
        int   best;
        logic ok;
        best = 0;
        for (int kp = 1; kp < width; kp++) begin
            if (kp <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < kp; i++) begin
                    if (seqdet_sbit(pattern, width, k, x, k + 1 - kp + i) !=
                        pattern[4'(width - 1 - i)])
                        ok = 1'b0;
                end
                if (ok)
                    best = kp;
            end
        end
        return best;
    endfunction

    function automatic int seqdet_border(input logic [SEQDET_MAX_W-1:0] pattern,
                                         input int width);
        int   best;
        logic ok;
        best = 0;
        for (int len = 1; len < width; len++) begin
            ok = 1'b1;
            for (int i = 0; i < len; i++) begin
                if (pattern[4'(width - 1 - i)] != pattern[4'(len - 1 - i)])
                    ok = 1'b0;
            end
            if (ok)
                best = len;
        end
        return best;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Generic saturating up-counter with synchronous clear.
module seqdet_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector built on an elaboration-time KMP transition table.
// Define SEQDET_COUNT_EN to add the saturating match_cnt output.
//
// state | meaning
// 0     | no prefix of PATTERN matched
// k     | last k accepted bits equal the first k bits of PATTERN (k <= WIDTH-1)
// >=W   | illegal encoding, forced back to 0 on the next clock
module seq_detect_param
    import seqdet_pkg::*;
#(
    parameter int               WIDTH   = 5,
    parameter logic [WIDTH-1:0] PATTERN = 5'b10101,
    parameter int               CNT_W   = 8,
    localparam int              SW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    output logic             z,
    output logic [SW-1:0]    state
`ifdef SEQDET_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int            NS       = 1 << SW;
    localparam logic [SW-1:0] LAST     = SW'(WIDTH - 1);
    localparam logic [SW-1:0] BORDER_S = SW'(seqdet_border(16'(PATTERN), WIDTH));

    logic [SW-1:0] nxt_tbl [NS][2];
    logic          legal   [NS];
    logic          hit;

    // The table covers every encoding so that illegal states index safely.
    for (genvar k = 0; k < NS; k++) begin : g_state
        if (k < WIDTH) begin : g_valid
            assign legal[k] = 1'b1;
            for (genvar b = 0; b < 2; b++) begin : g_bit
                assign nxt_tbl[k][b] = SW'(seqdet_next(16'(PATTERN), WIDTH, k, 1'(b)));
            end
        end else begin : g_invalid
            assign legal[k]      = 1'b0;
            assign nxt_tbl[k][0] = '0;
            assign nxt_tbl[k][1] = '0;
        end
    end

    assign hit = en && (state == LAST) && (x == PATTERN[0]);
    assign z   = hit && !rst;

    always_ff @(posedge clk) begin
        if (rst)
            state <= '0;
        else if (!legal[state])
            state <= '0;
        else if (en) begin
            if (hit)
                state <= (seqdet_mode_e'(overlap) == MODE_OVL) ? BORDER_S : '0;
            else
                state <= nxt_tbl[state][x];
        end
    end

`ifdef SEQDET_COUNT_EN
    seqdet_sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk (clk),
        .clr (rst),
        .inc (z),
        .cnt (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: directed vector table, WIDTH=4 saturation case,
// and randomized traffic compared against a bit-history reference model.
module tb_seq_detect_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, x, overlap, z;
    logic [2:0] state;
    logic       rst4, en4, x4, ovl4, z4;
    logic [1:0] state4;
`ifdef SEQDET_COUNT_EN
    logic [7:0] match_cnt;
    logic [1:0] match_cnt4;
`endif

    seq_detect_param dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap), .z(z), .state(state)
`ifdef SEQDET_COUNT_EN
        , .match_cnt(match_cnt)
`endif
    );

    seq_detect_param #(.WIDTH(4), .PATTERN(4'b1111), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .x(x4), .overlap(ovl4), .z(z4), .state(state4)
`ifdef SEQDET_COUNT_EN
        , .match_cnt(match_cnt4)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: accepted bits since the last reset / non-overlapping match.
    localparam int W = 5;
    bit pat_bits [W] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit hist [$];
    int mcnt = 0;

    function automatic bit suffix_is_prefix(input int k);
        int n;
        n = hist.size();
        if (n < k) return 1'b0;
        for (int i = 0; i < k; i++)
            if (hist[n - k + i] != pat_bits[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_state();
        for (int k = W - 1; k >= 1; k--)
            if (suffix_is_prefix(k)) return k;
        return 0;
    endfunction

    function automatic bit m_z(input bit xi);
        return suffix_is_prefix(W - 1) && (xi == pat_bits[W - 1]);
    endfunction

    task automatic m_update(input bit r, input bit e, input bit xi, input bit o);
        bit zz;
        if (r) begin
            hist.delete();
            mcnt = 0;
        end else if (e) begin
            zz = m_z(xi);
            hist.push_back(xi);
            if (hist.size() > 16) void'(hist.pop_front());
            if (zz) begin
                if (mcnt < 255) mcnt++;
                if (!o) hist.delete();
            end
        end
    endtask

    typedef struct {
        bit r; bit e; bit x; bit o;
        bit ez; int est; int ecnt;
    } vec_t;
    vec_t tbl [$];

    function automatic void add(input bit r, input bit e, input bit xi, input bit o,
                                input bit ez, input int est, input int ecnt);
        vec_t v;
        v.r = r; v.e = e; v.x = xi; v.o = o; v.ez = ez; v.est = est; v.ecnt = ecnt;
        tbl.push_back(v);
    endfunction

    task automatic drive(input bit r, input bit e, input bit xi, input bit o);
        @(negedge clk);
        rst = r; en = e; x = xi; overlap = o;
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; x = 1'b0; overlap = 1'b1;
        rst4 = 1'b1; en4 = 1'b0; x4 = 1'b0; ovl4 = 1'b1;

        // overlapping 1010101
        add(1,0,0,1, 0,0,0);
        add(0,1,1,1, 0,1,0); add(0,1,0,1, 0,2,0); add(0,1,1,1, 0,3,0);
        add(0,1,0,1, 0,4,0); add(0,1,1,1, 1,3,1); add(0,1,0,1, 0,4,1);
        add(0,1,1,1, 1,3,2);
        // reach state 4, then reset with a matching bit present: z must stay low
        add(0,1,0,1, 0,4,2); add(1,1,1,1, 0,0,0);
        // non-overlapping 1010101
        add(0,1,1,0, 0,1,0); add(0,1,0,0, 0,2,0); add(0,1,1,0, 0,3,0);
        add(0,1,0,0, 0,4,0); add(0,1,1,0, 1,0,1); add(0,1,0,0, 0,0,1);
        add(0,1,1,0, 0,1,1);
        // 1010010101: failure transition to 0, match on bit 10
        add(1,0,0,1, 0,0,0);
        add(0,1,1,1, 0,1,0); add(0,1,0,1, 0,2,0); add(0,1,1,1, 0,3,0);
        add(0,1,0,1, 0,4,0); add(0,1,0,1, 0,0,0); add(0,1,1,1, 0,1,0);
        add(0,1,0,1, 0,2,0); add(0,1,1,1, 0,3,0); add(0,1,0,1, 0,4,0);
        add(0,1,1,1, 1,3,1);
        // en=0 holds state and masks z
        add(1,0,0,1, 0,0,0);
        add(0,1,1,1, 0,1,0); add(0,1,0,1, 0,2,0); add(0,1,1,1, 0,3,0);
        add(0,0,1,1, 0,3,0); add(0,0,0,1, 0,3,0); add(0,0,1,1, 0,3,0);
        add(0,1,0,1, 0,4,0); add(0,0,1,1, 0,4,0); add(0,1,1,1, 1,3,1);
        // reset mid-pattern discards the prefix
        add(1,0,0,1, 0,0,0);
        add(0,1,1,1, 0,1,0); add(0,1,0,1, 0,2,0); add(0,1,1,1, 0,3,0);
        add(0,1,0,1, 0,4,0); add(1,0,1,1, 0,0,0); add(0,1,1,1, 0,1,0);
        // overlap change while idle does not move state; it rules the next match
        add(0,1,0,1, 0,2,0); add(0,1,1,1, 0,3,0); add(0,1,0,1, 0,4,0);
        add(0,0,1,0, 0,4,0); add(0,1,1,0, 1,0,1); add(0,0,0,1, 0,0,1);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].e, tbl[i].x, tbl[i].o);
            chk($sformatf("vec%0d z", i), int'(z), int'(tbl[i].ez));
            m_update(tbl[i].r, tbl[i].e, tbl[i].x, tbl[i].o);
            @(posedge clk); #1;
            chk($sformatf("vec%0d state", i), int'(state), tbl[i].est);
`ifdef SEQDET_COUNT_EN
            chk($sformatf("vec%0d cnt", i), int'(match_cnt), tbl[i].ecnt);
`endif
        end

        // WIDTH=4 all-ones pattern with overlap: z on bits 4..10
        @(negedge clk); rst4 = 1'b1; en4 = 1'b0;
        @(posedge clk); #1;
        chk("w4 reset state", int'(state4), 0);
        for (int b = 1; b <= 10; b++) begin
            @(negedge clk); rst4 = 1'b0; en4 = 1'b1; x4 = 1'b1; ovl4 = 1'b1;
            #1;
            chk($sformatf("w4 bit%0d z", b), int'(z4), (b >= 4) ? 1 : 0);
            @(posedge clk); #1;
            chk($sformatf("w4 bit%0d state", b), int'(state4), (b >= 3) ? 3 : b);
`ifdef SEQDET_COUNT_EN
            chk($sformatf("w4 bit%0d cnt", b), int'(match_cnt4), (b >= 6) ? 3 : ((b >= 4) ? b - 3 : 0));
`endif
        end
        @(negedge clk); en4 = 1'b0; rst4 = 1'b1;

        // randomized traffic against the reference model, biased toward the pattern
        for (int n = 0; n < 600; n++) begin
            bit r, e, xi, o;
            r  = ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 3) != 0);
            xi = ($urandom_range(0, 3) == 0) ? ~x : x;
            if ($urandom_range(0, 2) == 0) xi = pat_bits[m_state()];
            o  = ($urandom_range(0, 29) == 0) ? ~overlap : overlap;
            drive(r, e, xi, o);
            chk($sformatf("rnd%0d z", n), int'(z), (!r && e && m_z(xi)) ? 1 : 0);
            m_update(r, e, xi, o);
            @(posedge clk); #1;
            chk($sformatf("rnd%0d state", n), int'(state), m_state());
`ifdef SEQDET_COUNT_EN
            chk($sformatf("rnd%0d cnt", n), int'(match_cnt), mcnt);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
